// File: rtl/multicycle_control_pkg.sv
// Shared types, opcodes and decode helpers for the multicycle control FSM
// and the datapath_control interface.
// Optional feature macro: CONTROL_TRAP_ILLEGAL_EN (adds the HALT state).
package datapath_control_types;

  typedef enum logic [1:0] {ALU_X_ZERO, ALU_X_RS1, ALU_X_PC} alu_x_t;
  typedef enum logic {ALU_Y_RS2, ALU_Y_IMMED} alu_y_t;
  typedef enum logic {MEM_ADDR_PC, MEM_ADDR_ALU} mem_addr_t;
  typedef enum logic [1:0] {RF_D_ALU, RF_D_MEM, RF_D_PC4} regfile_d_t;

  // Encoded to match funct3[1:0] of loads and stores.
  typedef enum logic [1:0] {
    MW_BYTE = 2'd0,
    MW_HALF = 2'd1,
    MW_WORD = 2'd2
  } mem_width_t;

  // Compare ops produce their result in alu_w[0].
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_t;

`ifdef CONTROL_TRAP_ILLEGAL_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_HALT
  } control_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH
  } control_state_t;
`endif

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Register/immediate arithmetic; alt selects SUB/SRA.
  function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t branch_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  branch_op = ALU_EQ;
      3'b001:  branch_op = ALU_NE;
      3'b100:  branch_op = ALU_LT;
      3'b101:  branch_op = ALU_GE;
      3'b110:  branch_op = ALU_LTU;
      default: branch_op = ALU_GEU;
    endcase
  endfunction

  // True for opcodes/funct3 combinations this core implements.
  function automatic logic instr_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP_IMM: instr_legal = 1'b1;
      OPC_JALR:   instr_legal = (funct3 == 3'b000);
      OPC_BRANCH: instr_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_LOAD:   instr_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_STORE:  instr_legal = (funct3 <= 3'b010);
      default:    instr_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/datapath_control.sv
// Control/datapath link: the control side drives selects, ALU op, register
// file and memory controls; the datapath returns memory read data and the
// ALU result.
interface datapath_control;
  import datapath_control_types::*;

  logic [31:0] pc;
  logic [31:0] immed;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  alu_op_t     alu_op;
  alu_x_t      alu_x;
  alu_y_t      alu_y;
  mem_addr_t   mem_addr;
  logic        mem_valid;
  logic        mem_we;
  mem_width_t  mem_width;
  logic        mem_signed;
  logic        regfile_we;
  regfile_d_t  regfile_d;
  logic [31:0] mem_rd;
  logic [31:0] alu_w;

  modport control (
    output pc, immed, rs1, rs2, rd, alu_op, alu_x, alu_y, mem_addr,
           mem_valid, mem_we, mem_width, mem_signed, regfile_we, regfile_d,
    input  mem_rd, alu_w
  );

  modport datapath (
    input  pc, immed, rs1, rs2, rd, alu_op, alu_x, alu_y, mem_addr,
           mem_valid, mem_we, mem_width, mem_signed, regfile_we, regfile_d,
    output mem_rd, alu_w
  );
endinterface

// File: rtl/multicycle_control_immed_decoder.sv
// RV32I immediate decoder: picks the I/S/B/U/J format from the opcode and
// returns the sign-extended 32-bit immediate (zero for R-type/unknown).
module immed_decoder
  import datapath_control_types::*;
(
  input  logic [31:0] ir,
  output logic [31:0] immed
);

  // Format select by opcode.
  always_comb begin
    immed = 32'h0;
    case (ir[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        immed = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:
        immed = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:
        immed = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        immed = {ir[31:12], 12'h000};
      OPC_JAL:
        immed = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        immed = 32'h0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetches into IR, decodes, and sequences the
// datapath through EXEC/MEM/BRANCH. Owns the architectural PC.
// Optional feature macro: CONTROL_TRAP_ILLEGAL_EN -- when defined, illegal
// instructions park the FSM in HALT with illegal=1; otherwise they run as NOP.
module multicycle_control
  import datapath_control_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  datapath_control.control dp,
  input  logic             mem_ready,
  output logic             illegal
);

  control_state_t state_reg;
  logic [31:0]    pc_reg;
  logic [31:0]    ir_reg;
  logic [31:0]    immed_w;
  logic [31:0]    pc_plus4;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           instr_ok;
  logic           is_mem_op;

  assign opcode    = ir_reg[6:0];
  assign funct3    = ir_reg[14:12];
  assign pc_plus4  = pc_reg + 32'd4;
  assign instr_ok  = instr_legal(opcode, funct3);
  assign is_mem_op = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

  immed_decoder u_immed (
    .ir    (ir_reg),
    .immed (immed_w)
  );

`ifdef CONTROL_TRAP_ILLEGAL_EN
  logic illegal_reg;
  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  // State, PC and IR sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= NOP_INSTR;
`ifdef CONTROL_TRAP_ILLEGAL_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: state_reg <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg    <= dp.mem_rd;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!instr_ok) begin
`ifdef CONTROL_TRAP_ILLEGAL_EN
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
`else
            state_reg <= S_EXEC;
`endif
          end else if (is_mem_op) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (instr_ok && opcode == OPC_BRANCH && dp.alu_w[0]) begin
            // Taken: the target is computed in BRANCH, pc stays put.
            state_reg <= S_BRANCH;
          end else begin
            state_reg <= S_FETCH;
            if (instr_ok && opcode == OPC_JAL)
              pc_reg <= dp.alu_w;
            else if (instr_ok && opcode == OPC_JALR)
              pc_reg <= dp.alu_w & ~32'h1;
            else
              pc_reg <= pc_plus4;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            pc_reg    <= pc_plus4;
            state_reg <= S_FETCH;
          end
        end
        S_BRANCH: begin
          pc_reg    <= dp.alu_w;
          state_reg <= S_FETCH;
        end
`ifdef CONTROL_TRAP_ILLEGAL_EN
        S_HALT: state_reg <= S_HALT;
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from state and IR.
  always_comb begin
    dp.pc         = pc_reg;
    dp.immed      = immed_w;
    dp.rs1        = ir_reg[19:15];
    dp.rs2        = ir_reg[24:20];
    dp.rd         = ir_reg[11:7];
    dp.alu_op     = ALU_ADD;
    dp.alu_x      = ALU_X_PC;
    dp.alu_y      = ALU_Y_IMMED;
    dp.mem_addr   = MEM_ADDR_PC;
    dp.mem_valid  = 1'b0;
    dp.mem_we     = 1'b0;
    dp.mem_width  = MW_WORD;
    dp.mem_signed = 1'b0;
    dp.regfile_we = 1'b0;
    dp.regfile_d  = RF_D_ALU;
    case (state_reg)
      S_FETCH: dp.mem_valid = 1'b1;
      S_EXEC: begin
        if (instr_ok) begin
          case (opcode)
            OPC_OP: begin
              dp.alu_x      = ALU_X_RS1;
              dp.alu_y      = ALU_Y_RS2;
              dp.alu_op     = arith_op(funct3, ir_reg[30]);
              dp.regfile_we = 1'b1;
            end
            OPC_OP_IMM: begin
              // Bit 30 is part of the immediate except for SRAI.
              dp.alu_x      = ALU_X_RS1;
              dp.alu_op     = arith_op(funct3, ir_reg[30] && funct3 == 3'b101);
              dp.regfile_we = 1'b1;
            end
            OPC_LUI: begin
              dp.alu_x      = ALU_X_ZERO;
              dp.regfile_we = 1'b1;
            end
            OPC_AUIPC: dp.regfile_we = 1'b1;
            OPC_JAL: begin
              dp.regfile_d  = RF_D_PC4;
              dp.regfile_we = 1'b1;
            end
            OPC_JALR: begin
              dp.alu_x      = ALU_X_RS1;
              dp.regfile_d  = RF_D_PC4;
              dp.regfile_we = 1'b1;
            end
            OPC_BRANCH: begin
              dp.alu_x  = ALU_X_RS1;
              dp.alu_y  = ALU_Y_RS2;
              dp.alu_op = branch_op(funct3);
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        dp.alu_x      = ALU_X_RS1;
        dp.mem_addr   = MEM_ADDR_ALU;
        dp.mem_valid  = 1'b1;
        dp.mem_width  = mem_width_t'(funct3[1:0]);
        dp.mem_signed = ~funct3[2];
        dp.mem_we     = (opcode == OPC_STORE);
        if (opcode == OPC_LOAD && mem_ready) begin
          dp.regfile_d  = RF_D_MEM;
          dp.regfile_we = 1'b1;
        end
      end
      default: ;
    endcase
    if (ir_reg[11:7] == 5'd0)
      dp.regfile_we = 1'b0;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the bench plays memory and ALU,
// hand-feeds instructions and checks the decoded control outputs.
module tb_multicycle_control;
  import datapath_control_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ready = 1'b0;
  logic illegal;
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   valid_cycles;

  datapath_control dp_if ();

  multicycle_control #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dp        (dp_if),
    .mem_ready (mem_ready),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input alu_x_t ax, input alu_y_t ay,
                            input alu_op_t op, input logic we, input regfile_d_t d);
    check_value({tag, ".alu_x"}, 32'(dp_if.alu_x), 32'(ax));
    check_value({tag, ".alu_y"}, 32'(dp_if.alu_y), 32'(ay));
    check_value({tag, ".alu_op"}, 32'(dp_if.alu_op), 32'(op));
    check_value({tag, ".regfile_we"}, 32'(dp_if.regfile_we), 32'(we));
    check_value({tag, ".regfile_d"}, 32'(dp_if.regfile_d), 32'(d));
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH right after cyc(): checks the fetch request, returns the
  // instruction with zero wait, and leaves the FSM in DECODE.
  task automatic fetch_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] instr);
    #1;
    check_value({tag, ".fetch_valid"}, 32'(dp_if.mem_valid), 32'd1);
    check_value({tag, ".fetch_pc"}, dp_if.pc, exp_pc);
    $display("txn %s: pc=0x%08h instr=0x%08h", tag, dp_if.pc, instr);
    mem_ready = 1'b1;
    dp_if.mem_rd = instr;
    cyc();
    mem_ready = 1'b0;
    dp_if.mem_rd = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dp_if.mem_rd = 32'h0;
    dp_if.alu_w  = 32'h0;

    // Reset held three cycles.
    repeat (3) cyc();
    #1;
    check_value("rst.mem_valid", 32'(dp_if.mem_valid), 32'd0);
    check_value("rst.pc", dp_if.pc, 32'h0);
    check_value("rst.illegal", 32'(illegal), 32'd0);
    check_value("rst.rd", 32'(dp_if.rd), 32'd0);
    check_value("rst.immed", dp_if.immed, 32'h0);
    check_value("rst.regfile_we", 32'(dp_if.regfile_we), 32'd0);
    rst_n = 1'b1;
    check_value("idle.mem_valid", 32'(dp_if.mem_valid), 32'd0);
    cyc();
    #1;
    check_value("fetch.mem_addr", 32'(dp_if.mem_addr), 32'(MEM_ADDR_PC));
    check_value("fetch.mem_width", 32'(dp_if.mem_width), 32'(MW_WORD));

    // ADDI x1,x0,5
    fetch_instr("addi", 32'h0, 32'h0050_0093);
    #1;
    check_value("addi.decode_valid", 32'(dp_if.mem_valid), 32'd0);
    check_value("addi.decode_we", 32'(dp_if.regfile_we), 32'd0);
    cyc();
    #1;
    check_value("addi.rd", 32'(dp_if.rd), 32'd1);
    check_value("addi.immed", dp_if.immed, 32'd5);
    check_ctrl("addi", ALU_X_RS1, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_ALU);
    cyc();

    // LW x2,8(x1) with three wait cycles
    fetch_instr("lw", 32'h4, 32'h0080_A103);
    cyc();
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dp_if.mem_valid) valid_cycles++;
      check_value("lw.wait_we", 32'(dp_if.regfile_we), 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    dp_if.mem_rd = 32'hDEAD_BEEF;
    #1;
    if (dp_if.mem_valid) valid_cycles++;
    check_value("lw.mem_addr", 32'(dp_if.mem_addr), 32'(MEM_ADDR_ALU));
    check_value("lw.mem_width", 32'(dp_if.mem_width), 32'(MW_WORD));
    check_value("lw.mem_signed", 32'(dp_if.mem_signed), 32'd1);
    check_value("lw.mem_we", 32'(dp_if.mem_we), 32'd0);
    check_value("lw.immed", dp_if.immed, 32'd8);
    check_ctrl("lw.ready", ALU_X_RS1, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_MEM);
    cyc();
    mem_ready = 1'b0;
    check_value("lw.valid_cycles", 32'(valid_cycles), 32'd4);

    // SW x2,4(x1), zero wait
    fetch_instr("sw", 32'h8, 32'h0020_A223);
    cyc();
    mem_ready = 1'b1;
    #1;
    check_value("sw.mem_valid", 32'(dp_if.mem_valid), 32'd1);
    check_value("sw.mem_we", 32'(dp_if.mem_we), 32'd1);
    check_value("sw.regfile_we", 32'(dp_if.regfile_we), 32'd0);
    check_value("sw.immed", dp_if.immed, 32'd4);
    cyc();
    mem_ready = 1'b0;

    // LUI x3,0x12345
    fetch_instr("lui", 32'hC, 32'h1234_51B7);
    cyc();
    #1;
    check_value("lui.immed", dp_if.immed, 32'h1234_5000);
    check_ctrl("lui", ALU_X_ZERO, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_ALU);
    cyc();

    // BEQ x0,x0,-8 not taken
    fetch_instr("beq_nt", 32'h10, 32'hFE00_0CE3);
    cyc();
    dp_if.alu_w = 32'h0;
    #1;
    check_value("beq_nt.immed", dp_if.immed, 32'hFFFF_FFF8);
    check_ctrl("beq_nt", ALU_X_RS1, ALU_Y_RS2, ALU_EQ, 1'b0, RF_D_ALU);
    cyc();

    // JAL x0,-4: rd==0 suppresses the link write
    fetch_instr("jal", 32'h14, 32'hFFDF_F06F);
    cyc();
    dp_if.alu_w = 32'h10;
    #1;
    check_value("jal.immed", dp_if.immed, 32'hFFFF_FFFC);
    check_ctrl("jal", ALU_X_PC, ALU_Y_IMMED, ALU_ADD, 1'b0, RF_D_PC4);
    cyc();
    dp_if.alu_w = 32'h0;

    // BEQ x0,x0,-8 taken
    fetch_instr("beq_t", 32'h10, 32'hFE00_0CE3);
    cyc();
    dp_if.alu_w = 32'h1;
    #1;
    check_ctrl("beq_t", ALU_X_RS1, ALU_Y_RS2, ALU_EQ, 1'b0, RF_D_ALU);
    cyc();
    dp_if.alu_w = 32'h8;
    #1;
    check_ctrl("beq_t.branch", ALU_X_PC, ALU_Y_IMMED, ALU_ADD, 1'b0, RF_D_ALU);
    check_value("beq_t.branch_valid", 32'(dp_if.mem_valid), 32'd0);
    cyc();
    dp_if.alu_w = 32'h0;

    // JALR x1,0(x1) with target 0x101 -> 0x100
    fetch_instr("jalr", 32'h8, 32'h0000_80E7);
    cyc();
    dp_if.alu_w = 32'h101;
    #1;
    check_value("jalr.rd", 32'(dp_if.rd), 32'd1);
    check_ctrl("jalr", ALU_X_RS1, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_PC4);
    cyc();
    dp_if.alu_w = 32'h0;

    // SUB x5,x6,x7
    fetch_instr("sub", 32'h100, 32'h4073_02B3);
    cyc();
    #1;
    check_value("sub.rs1", 32'(dp_if.rs1), 32'd6);
    check_value("sub.rs2", 32'(dp_if.rs2), 32'd7);
    check_ctrl("sub", ALU_X_RS1, ALU_Y_RS2, ALU_SUB, 1'b1, RF_D_ALU);
    cyc();

    // ADDI x1,x1,-1: bit 30 set but still ADD
    fetch_instr("addi_neg", 32'h104, 32'hFFF0_8093);
    cyc();
    #1;
    check_value("addi_neg.immed", dp_if.immed, 32'hFFFF_FFFF);
    check_ctrl("addi_neg", ALU_X_RS1, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_ALU);
    cyc();

    // SRAI x2,x2,3
    fetch_instr("srai", 32'h108, 32'h4031_5113);
    cyc();
    #1;
    check_ctrl("srai", ALU_X_RS1, ALU_Y_IMMED, ALU_SRA, 1'b1, RF_D_ALU);
    cyc();

    // AUIPC x4,0x1
    fetch_instr("auipc", 32'h10C, 32'h0000_1217);
    cyc();
    #1;
    check_value("auipc.immed", dp_if.immed, 32'h0000_1000);
    check_ctrl("auipc", ALU_X_PC, ALU_Y_IMMED, ALU_ADD, 1'b1, RF_D_ALU);
    cyc();

    // Opcode 0x7F with rd=1
    fetch_instr("illegal", 32'h110, 32'h0000_00FF);
    #1;
    check_value("illegal.decode_flag", 32'(illegal), 32'd0);
    cyc();
`ifdef CONTROL_TRAP_ILLEGAL_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      check_value("halt.illegal", 32'(illegal), 32'd1);
      check_value("halt.mem_valid", 32'(dp_if.mem_valid), 32'd0);
      check_value("halt.regfile_we", 32'(dp_if.regfile_we), 32'd0);
      check_value("halt.pc", dp_if.pc, 32'h110);
      cyc();
    end
`else
    #1;
    check_value("nop.regfile_we", 32'(dp_if.regfile_we), 32'd0);
    check_value("nop.mem_valid", 32'(dp_if.mem_valid), 32'd0);
    check_value("nop.illegal", 32'(illegal), 32'd0);
    cyc();
    #1;
    check_value("nop.next_valid", 32'(dp_if.mem_valid), 32'd1);
    check_value("nop.next_pc", dp_if.pc, 32'h114);
`endif

    // Asynchronous reset in the middle of a memory access
    rst_n = 1'b0;
    #1;
    check_value("rst2.pc", dp_if.pc, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    fetch_instr("lw2", 32'h0, 32'h0080_A103);
    cyc();
    #1;
    check_value("lw2.mem_valid", 32'(dp_if.mem_valid), 32'd1);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_value("rst_mem.mem_valid", 32'(dp_if.mem_valid), 32'd0);
    check_value("rst_mem.regfile_we", 32'(dp_if.regfile_we), 32'd0);
    cyc();
    check_value("rst_mem.held_valid", 32'(dp_if.mem_valid), 32'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
